bd_sector_buf: RTL and testbench
================================

# bd_sector_buf

Word-wide sector buffer between the xbus disk controller and the block-device engine (`mmc_block_dev` / `ide_block_dev`). It decouples the controller's bus-paced word transfers from the device's serial-paced `bd_rd`/`bd_wr` strobes by holding up to one full 512-byte sector as 256 × 16-bit words. It also reports sector-boundary completion on each side. The same instance carries both directions: disk reads fill it from the device side, and disk writes fill it from the controller side. The controller selects the direction by which side it connects to which port.

## Interface
- `WIDTH`, 16, data word width in bits.
- `DEPTH_LOG2`, 8, log2 of buffer depth (256 words = one sector).
- `clk`  in  1  single clock for all logic.
- `reset_n`  in  1  reset, asynchronous and active-low. One clock; reset is asynchronous and active-low.
- `flush`  in  1  synchronous clear of pointers, count, flags and sector counters.
- `wr_en`  in  1  push request; the word is accepted when `wr_en & wr_ready`.
- `wr_data`  in  WIDTH  word to push.
- `wr_ready`  out  1  space available (not full).
- `rd_en`  in  1  pop request; the word is consumed when `rd_en & rd_valid`.
- `rd_data`  out  WIDTH  head word, registered, first-word-fall-through.
- `rd_valid`  out  1  `rd_data` holds a valid word.
- `count`  out  DEPTH_LOG2+1  words held, including the head in the output register (0..256).
- `sector_in_done`  out  1  one-cycle pulse after every 256th accepted push.
- `sector_out_done`  out  1  one-cycle pulse after every 256th accepted pop.
- `overflow`  out  1  sticky; set by `wr_en` while `wr_ready` is low.
- `underflow`  out  1  sticky; set by `rd_en` while `rd_valid` is low.

## Operation
- Storage is a 2^DEPTH_LOG2 × WIDTH synchronous-read array, inferable as block RAM, plus one output register.
- Write pointer `wp` and memory read pointer `rp` are each DEPTH_LOG2 bits and wrap modulo 256 with no special case.
- Prefetch:
  - When the output register is empty, or is being popped this cycle, and the array holds unread words, the array is read at `rp` and `rp` increments.
  - The fetched word lands in the output register on the following edge, and `rd_valid` follows.
- `count` tracks accepted pushes minus accepted pops:
  - +1 on push only, −1 on pop only.
  - Unchanged on a simultaneous push and pop.
  - `wr_ready = (count != 256)`.
- A rejected push does not write the array, move `wp`, or change `count`. It sets `overflow`.
- A rejected pop changes nothing except setting `underflow`.
- The sector counters `in_cnt` and `out_cnt` are 8 bits each and increment on accepted push and accepted pop respectively. When a counter wraps from 255 to 0, it pulses `sector_in_done` or `sector_out_done` on the next cycle.
- `flush` has priority over same-cycle `wr_en` and `rd_en`. On flush:
  - Everything returns to reset values on the next edge.
  - Any pushed word is discarded.
  - No done pulse is generated.
- Reset values: `wr_ready`=1, `rd_valid`=0, `rd_data`=0, `count`=0, `sector_in_done`=0, `sector_out_done`=0, `overflow`=0, `underflow`=0; all pointers and counters are 0.
- Assertion of `reset_n` mid-transfer clears everything immediately (asynchronously). The contents of the array are don't-care after reset.

## Timing
- Push-to-visible latency on an empty buffer:
  - Push accepted at edge N; `count`=1 after N.
  - Array read at edge N+1; `rd_valid`=1 and `rd_data` equal to the pushed word after N+1 (2 edges total).
- Steady-state streaming: with the buffer non-empty and `rd_en` held high, one word is popped per clock with no bubbles. Each pop at edge M presents the next word after M.
- `wr_ready` falls after the edge that accepts the 256th resident word. It rises after the edge of the first pop from full.
- Simultaneous push and pop at full: the push is rejected because `wr_ready` is sampled before the pop. The pop proceeds, and `count` becomes 255.
- Simultaneous push and pop when `count`=1: both are accepted, and `rd_data` shows the new word one edge later. A single cycle of `rd_valid`=0 is permitted only in this case.
- Sector done pulses are high for exactly one cycle, starting after the edge that follows the 256th transfer.
- `overflow` and `underflow` set after the offending edge and hold until `flush` or reset.

## Test plan
- Reset, then push 0x0000..0x00FF one per cycle; pop all with `rd_en` held high. Required: popped values are 0x0000..0x00FF in order, `wr_ready`=0 after the 256th push, `count` peaks at 256, and exactly one `sector_in_done` and one `sector_out_done` pulse occur.
- Single push of 0x1234 into an empty buffer. Required: `rd_valid` and `rd_data`=0x1234 exactly 2 edges after the push, `count`=1.
- Fill to 256, then hold `wr_en`=1 with 0xDEAD and `rd_en`=1 for one cycle. Required: 0xDEAD is not stored, `overflow`=1, `count`=255, and the first word popped is the original head.
- Streaming: push 512 words while popping concurrently with random `rd_en` gaps. Required: data order is preserved across pointer wrap, and two of each done pulse occur.
- Push 10 words, then assert `flush` together with `wr_en` and `rd_en`. Required: next cycle `count`=0, `rd_valid`=0, flags are 0, and the next 256 pushes produce one `sector_in_done`.
- Pop with an empty buffer, then drop `reset_n` while 100 words are resident. Required: `underflow`=1 after the pop, and all outputs at reset values immediately on `reset_n` low, without waiting for `clk`.

Source files
------------

// File: rtl/bd_sector_buf.sv
// ---------------------------------------------------------------------------
// bd_sector_buf
//
// Purpose:
//   One-sector (256 x 16-bit) elastic buffer between the xbus disk controller
//   and the block-device engine. Whichever side produces data drives the push
//   port and the other side drains the pop port, so one instance serves both
//   disk reads and disk writes. Each side also gets a one-cycle pulse when it
//   has moved a whole sector.
//
// Ports:
//   clk             in   single clock for all logic
//   reset_n         in   asynchronous active-low reset
//   flush           in   synchronous clear of pointers, count, flags, counters
//   wr_en/wr_data   in   push request and word; accepted when wr_en & wr_ready
//   wr_ready        out  buffer not full
//   rd_en           in   pop request; consumed when rd_en & rd_valid
//   rd_data         out  registered head word (first-word-fall-through)
//   rd_valid        out  rd_data holds a valid word
//   count           out  words held, including the head register (0..256)
//   sector_in_done  out  one-cycle pulse after every 256th accepted push
//   sector_out_done out  one-cycle pulse after every 256th accepted pop
//   overflow        out  sticky: push attempted while full
//   underflow       out  sticky: pop attempted while rd_valid low
// ---------------------------------------------------------------------------
module bd_sector_buf #(
    parameter int WIDTH      = 16,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [WIDTH-1:0]      wr_data,
    output logic                  wr_ready,
    input  logic                  rd_en,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  rd_valid,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  sector_in_done,
    output logic                  sector_out_done,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int                  DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL  = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [WIDTH-1:0]      r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wp;
    logic [DEPTH_LOG2-1:0] r_rp;
    logic [DEPTH_LOG2:0]   r_count;
    logic [WIDTH-1:0]      r_rdData;
    logic                  r_rdValid;
    logic [DEPTH_LOG2-1:0] r_inCnt;
    logic [DEPTH_LOG2-1:0] r_outCnt;
    logic                  r_sectorInDone;
    logic                  r_sectorOutDone;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_wrReady;
    logic                  w_push;
    logic                  w_pop;
    logic [DEPTH_LOG2:0]   w_unread;
    logic                  w_fetch;

    assign w_wrReady = (r_count != FULL);
    assign w_push    = wr_en & w_wrReady & ~flush;
    assign w_pop     = rd_en & r_rdValid & ~flush;

    // Words still sitting in the array: everything counted minus the head
    // register when it is occupied.
    assign w_unread  = r_count - {{DEPTH_LOG2{1'b0}}, r_rdValid};

    // Refill the head register whenever it is empty or being drained this
    // cycle, so a held rd_en streams one word per clock with no bubbles.
    assign w_fetch   = ~flush & (~r_rdValid | w_pop) & (w_unread != '0);

    // The storage array has no reset so it can map onto block RAM; its
    // contents are meaningless until written after reset or flush.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wp] <= wr_data;
        end
    end

    // Pointers, occupancy and the head register. The head register doubles
    // as the synchronous read port of the array.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wp      <= '0;
            r_rp      <= '0;
            r_count   <= '0;
            r_rdData  <= '0;
            r_rdValid <= 1'b0;
        end else if (flush) begin
            r_wp      <= '0;
            r_rp      <= '0;
            r_count   <= '0;
            r_rdData  <= '0;
            r_rdValid <= 1'b0;
        end else begin
            if (w_push) begin
                r_wp <= r_wp + 1'b1;
            end
            if (w_fetch) begin
                r_rdData  <= r_mem[r_rp];
                r_rp      <= r_rp + 1'b1;
                r_rdValid <= 1'b1;
            end else if (w_pop) begin
                r_rdValid <= 1'b0;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sector counters wrap naturally; the pulse is registered from the
    // transfer that takes the counter from all-ones back to zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_inCnt         <= '0;
            r_outCnt        <= '0;
            r_sectorInDone  <= 1'b0;
            r_sectorOutDone <= 1'b0;
        end else if (flush) begin
            r_inCnt         <= '0;
            r_outCnt        <= '0;
            r_sectorInDone  <= 1'b0;
            r_sectorOutDone <= 1'b0;
        end else begin
            r_sectorInDone  <= w_push && (r_inCnt == '1);
            r_sectorOutDone <= w_pop && (r_outCnt == '1);
            if (w_push) begin
                r_inCnt <= r_inCnt + 1'b1;
            end
            if (w_pop) begin
                r_outCnt <= r_outCnt + 1'b1;
            end
        end
    end

    // Sticky error flags; only flush or reset clears them, and a flush cycle
    // never sets them even if the requests are illegal that cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (flush) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (wr_en && !w_wrReady) begin
                r_overflow <= 1'b1;
            end
            if (rd_en && !r_rdValid) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign wr_ready        = w_wrReady;
    assign rd_data         = r_rdData;
    assign rd_valid        = r_rdValid;
    assign count           = r_count;
    assign sector_in_done  = r_sectorInDone;
    assign sector_out_done = r_sectorOutDone;
    assign overflow        = r_overflow;
    assign underflow       = r_underflow;

endmodule

// File: tb/tb_bd_sector_buf.sv
// ---------------------------------------------------------------------------
// tb_bd_sector_buf
//
// Purpose:
//   Self-checking bench for bd_sector_buf. Accepted pushes are queued as the
//   expected pop order; every accepted pop is compared against the queue
//   head. A small occupancy/flag model provides count, wr_ready and the
//   sticky flags, and sector pulses are tallied against expected totals.
// ---------------------------------------------------------------------------
module tb_bd_sector_buf;

    logic        clk;
    logic        reset_n;
    logic        flush;
    logic        wr_en;
    logic [15:0] wr_data;
    logic        wr_ready;
    logic        rd_en;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic [8:0]  count;
    logic        sector_in_done;
    logic        sector_out_done;
    logic        overflow;
    logic        underflow;

    int checks = 0;
    int errors = 0;

    logic [15:0] scoreQ[$];
    int          mCount;
    int          mInCnt;
    int          mOutCnt;
    int          expIn;
    int          expOut;
    int          seenIn;
    int          seenOut;
    logic        mOverflow;
    logic        mUnderflow;

    bd_sector_buf #(.WIDTH(16), .DEPTH_LOG2(8)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .flush          (flush),
        .wr_en          (wr_en),
        .wr_data        (wr_data),
        .wr_ready       (wr_ready),
        .rd_en          (rd_en),
        .rd_data        (rd_data),
        .rd_valid       (rd_valid),
        .count          (count),
        .sector_in_done (sector_in_done),
        .sector_out_done(sector_out_done),
        .overflow       (overflow),
        .underflow      (underflow)
    );

    // Free-running 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single point of comparison: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     tag, actual, expected, $time);
        end
    endtask

    // Model returns to the post-reset / post-flush state
    task automatic resetModel();
        scoreQ.delete();
        mCount     = 0;
        mInCnt     = 0;
        mOutCnt    = 0;
        expIn      = 0;
        expOut     = 0;
        seenIn     = 0;
        seenOut    = 0;
        mOverflow  = 1'b0;
        mUnderflow = 1'b0;
    endtask

    // One clock of stimulus. Called #1 after a rising edge; predicts the
    // handshakes, advances one edge and checks the model afterwards.
    task automatic applyStimulus(input logic we, input logic [15:0] wd, input logic re);
        logic pushOk;
        logic popOk;
        wr_en   = we;
        wr_data = wd;
        rd_en   = re;
        pushOk  = we && (mCount != 256);
        popOk   = re && rd_valid;
        if (popOk) begin
            if (scoreQ.size() == 0) begin
                checkOutput("popFromEmptyModel", 32'(rd_data), 32'hFFFF_FFFF);
            end else begin
                checkOutput("rdData", 32'(rd_data), 32'(scoreQ.pop_front()));
            end
            mCount  = mCount - 1;
            mOutCnt = mOutCnt + 1;
            if (mOutCnt == 256) begin
                mOutCnt = 0;
                expOut  = expOut + 1;
            end
        end
        if (pushOk) begin
            scoreQ.push_back(wd);
            mCount = mCount + 1;
            mInCnt = mInCnt + 1;
            if (mInCnt == 256) begin
                mInCnt = 0;
                expIn  = expIn + 1;
            end
        end
        if (we && !pushOk) mOverflow = 1'b1;
        if (re && !rd_valid) mUnderflow = 1'b1;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        if (sector_in_done) seenIn++;
        if (sector_out_done) seenOut++;
        checkOutput("count", 32'(count), 32'(mCount));
        checkOutput("wrReady", 32'(wr_ready), 32'(mCount != 256));
        checkOutput("overflow", 32'(overflow), 32'(mOverflow));
        checkOutput("underflow", 32'(underflow), 32'(mUnderflow));
    endtask

    // Pop until the scoreboard empties, with a cycle budget
    task automatic drainAll();
        for (int i = 0; i < 2000 && scoreQ.size() > 0; i++) begin
            applyStimulus(1'b0, 16'h0, 1'b1);
        end
        checkOutput("drained", 32'(scoreQ.size()), 32'd0);
    endtask

    task automatic checkDone(input string tag);
        checkOutput({tag, "_inDone"}, 32'(seenIn), 32'(expIn));
        checkOutput({tag, "_outDone"}, 32'(seenOut), 32'(expOut));
    endtask

    // Flush with requests active; everything must be clear one edge later
    task automatic applyFlush(input logic we, input logic re);
        flush   = 1'b1;
        wr_en   = we;
        wr_data = 16'hBEEF;
        rd_en   = re;
        @(posedge clk);
        #1;
        flush = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        resetModel();
        checkOutput("flushCount", 32'(count), 32'd0);
        checkOutput("flushRdValid", 32'(rd_valid), 32'd0);
        checkOutput("flushWrReady", 32'(wr_ready), 32'd1);
        checkOutput("flushFlags", {28'd0, overflow, underflow, sector_in_done, sector_out_done}, 32'd0);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_count"}, 32'(count), 32'd0);
        checkOutput({tag, "_rdValid"}, 32'(rd_valid), 32'd0);
        checkOutput({tag, "_rdData"}, 32'(rd_data), 32'd0);
        checkOutput({tag, "_wrReady"}, 32'(wr_ready), 32'd1);
        checkOutput({tag, "_flags"}, {28'd0, overflow, underflow, sector_in_done, sector_out_done}, 32'd0);
    endtask

    initial begin
        int pushed;
        reset_n = 1'b0;
        flush   = 1'b0;
        wr_en   = 1'b0;
        wr_data = 16'h0;
        rd_en   = 1'b0;
        resetModel();
        #12;
        checkResetState("reset");
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Fill a whole sector, then stream it out with rd_en held high
        $display("[TB] fill and drain one sector");
        for (int i = 0; i < 256; i++) applyStimulus(1'b1, 16'(i), 1'b0);
        checkOutput("fullCount", 32'(count), 32'd256);
        applyStimulus(1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 256; i++) begin
            checkOutput("noBubble", 32'(rd_valid), 32'd1);
            applyStimulus(1'b0, 16'h0, 1'b1);
        end
        applyStimulus(1'b0, 16'h0, 1'b0);
        checkOutput("emptyRdValid", 32'(rd_valid), 32'd0);
        checkDone("sector1");
        checkOutput("sector1_inPulses", 32'(seenIn), 32'd1);
        checkOutput("sector1_outPulses", 32'(seenOut), 32'd1);

        // Push-to-visible latency of two edges
        $display("[TB] single word latency");
        applyFlush(1'b0, 1'b0);
        applyStimulus(1'b1, 16'h1234, 1'b0);
        checkOutput("lat1_rdValid", 32'(rd_valid), 32'd0);
        applyStimulus(1'b0, 16'h0, 1'b0);
        checkOutput("lat2_rdValid", 32'(rd_valid), 32'd1);
        checkOutput("lat2_rdData", 32'(rd_data), 32'h1234);
        drainAll();

        // Push and pop together while full: push rejected, pop proceeds
        $display("[TB] overflow at full");
        applyFlush(1'b0, 1'b0);
        for (int i = 0; i < 256; i++) applyStimulus(1'b1, 16'(16'h8000 + i), 1'b0);
        applyStimulus(1'b0, 16'h0, 1'b0);
        applyStimulus(1'b1, 16'hDEAD, 1'b1);
        checkOutput("ovfCount", 32'(count), 32'd255);
        checkOutput("ovfFlag", 32'(overflow), 32'd1);
        drainAll();

        // Concurrent streaming across pointer wrap with random pop gaps
        $display("[TB] streaming 512 words");
        applyFlush(1'b0, 1'b0);
        pushed = 0;
        for (int i = 0; i < 4000 && pushed < 512; i++) begin
            logic we;
            we = (mCount != 256);
            applyStimulus(we, 16'(16'h4000 + pushed), 1'($urandom_range(0, 3) != 0));
            if (we) pushed++;
        end
        checkOutput("streamPushed", 32'(pushed), 32'd512);
        drainAll();
        applyStimulus(1'b0, 16'h0, 1'b0);
        checkDone("stream");

        // Flush beats simultaneous push/pop, and sector counting restarts
        $display("[TB] flush with active requests");
        applyFlush(1'b0, 1'b0);
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 16'(16'h2000 + i), 1'b0);
        applyFlush(1'b1, 1'b1);
        for (int i = 0; i < 256; i++) applyStimulus(1'b1, 16'(16'h3000 + i), 1'b0);
        applyStimulus(1'b0, 16'h0, 1'b0);
        checkDone("afterFlush");
        checkOutput("afterFlush_inPulses", 32'(seenIn), 32'd1);

        // Underflow, then asynchronous reset with data resident
        $display("[TB] underflow and async reset");
        applyFlush(1'b0, 1'b0);
        applyStimulus(1'b0, 16'h0, 1'b1);
        checkOutput("uflFlag", 32'(underflow), 32'd1);
        for (int i = 0; i < 100; i++) applyStimulus(1'b1, 16'(16'h5000 + i), 1'b0);
        applyStimulus(1'b0, 16'h0, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        checkResetState("asyncReset");
        resetModel();
        #2;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 16'hA5A5, 1'b0);
        applyStimulus(1'b0, 16'h0, 1'b0);
        drainAll();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
